// File: rtl/fc_stream_driver.sv
// fc_stream_driver: packs a byte-stream inference frame onto a parallel FC layer and streams its INT8 results back out
//
// Ports:
//   clk, rst        single clock, synchronous active-high reset
//   s_data/s_valid/s_ready/s_params
//                   inbound bytes: INPUT_SIZE activations, then optionally
//                   OUTPUT_SIZE*INPUT_SIZE weights and OUTPUT_SIZE biases
//   fc_in_vec/fc_weights/fc_bias/fc_en
//                   flattened buses and one-cycle strobe to the layer
//   fc_out_vec/fc_valid
//                   layer result, captured only while waiting for it
//   m_data/m_valid/m_ready/m_last
//                   outbound result bytes, element 0 first
//   busy            a frame is in progress
module fc_stream_driver #(
    parameter int INPUT_SIZE  = 128,
    parameter int OUTPUT_SIZE = 10
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [7:0]                        s_data,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic                              s_params,
    output logic [INPUT_SIZE*8-1:0]           fc_in_vec,
    output logic [OUTPUT_SIZE*INPUT_SIZE*8-1:0] fc_weights,
    output logic [OUTPUT_SIZE*8-1:0]          fc_bias,
    output logic                              fc_en,
    input  logic [OUTPUT_SIZE*8-1:0]          fc_out_vec,
    input  logic                              fc_valid,
    output logic [7:0]                        m_data,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic                              m_last,
    output logic                              busy
);
    localparam int N_W = OUTPUT_SIZE * INPUT_SIZE;
    localparam int CW = (N_W > 1) ? $clog2(N_W) : 1;
    localparam logic [CW-1:0] LAST_IN = CW'(INPUT_SIZE - 1);
    localparam logic [CW-1:0] LAST_W  = CW'(N_W - 1);
    localparam logic [CW-1:0] LAST_O  = CW'(OUTPUT_SIZE - 1);

    typedef enum logic [2:0] {LOAD_IN, LOAD_W, LOAD_B, FIRE, WAIT, SEND} state_t;

    state_t                   state;
    logic [CW-1:0]            cnt;
    logic                     params;
    logic                     weights_loaded;
    logic [OUTPUT_SIZE*8-1:0] result;
    logic                     flag_now;

    // On byte 0 the flag is not yet registered, so use the live value; a
    // driver with no stored weights must always load them.
    assign flag_now = (cnt == '0) ? (s_params | ~weights_loaded) : params;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= LOAD_IN;
            cnt            <= '0;
            params         <= 1'b0;
            weights_loaded <= 1'b0;
            fc_in_vec      <= '0;
            fc_weights     <= '0;
            fc_bias        <= '0;
            result         <= '0;
        end else begin
            case (state)
                LOAD_IN: if (s_valid) begin
                    fc_in_vec[int'(cnt)*8 +: 8] <= s_data;
                    if (cnt == '0) params <= s_params | ~weights_loaded;
                    if (cnt == LAST_IN) begin
                        cnt   <= '0;
                        state <= flag_now ? LOAD_W : FIRE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LOAD_W: if (s_valid) begin
                    fc_weights[int'(cnt)*8 +: 8] <= s_data;
                    if (cnt == LAST_W) begin
                        cnt   <= '0;
                        state <= LOAD_B;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LOAD_B: if (s_valid) begin
                    fc_bias[int'(cnt)*8 +: 8] <= s_data;
                    if (cnt == LAST_O) begin
                        cnt            <= '0;
                        weights_loaded <= 1'b1;
                        state          <= FIRE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FIRE: state <= WAIT;
                WAIT: if (fc_valid) begin
                    result <= fc_out_vec;
                    state  <= SEND;
                end
                SEND: if (m_ready) begin
                    if (cnt == LAST_O) begin
                        cnt   <= '0;
                        state <= LOAD_IN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= LOAD_IN;
                end
            endcase
        end
    end

    // Gating with rst keeps every handshake output low during reset and
    // drops m_valid in the same cycle rst rises.
    assign s_ready = ~rst & (state == LOAD_IN || state == LOAD_W || state == LOAD_B);
    assign fc_en   = ~rst & (state == FIRE);
    assign m_valid = ~rst & (state == SEND);
    assign m_data  = m_valid ? result[int'(cnt)*8 +: 8] : 8'h00;
    assign m_last  = m_valid & (cnt == LAST_O);
    assign busy    = ~rst & (state != LOAD_IN || cnt != '0);
endmodule

// File: tb/tb_fc_stream_driver.sv
// tb_fc_stream_driver: randomized frame-level check of fc_stream_driver against a saturating dot-product model
module tb_fc_stream_driver;
    localparam int IS = 4;
    localparam int OS = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]         s_data = '0;
    logic               s_valid = 1'b0;
    logic               s_params = 1'b0;
    logic               s_ready;
    logic [IS*8-1:0]    fc_in_vec;
    logic [OS*IS*8-1:0] fc_weights;
    logic [OS*8-1:0]    fc_bias;
    logic               fc_en;
    logic [OS*8-1:0]    fc_out_vec;
    logic               fc_valid;
    logic [7:0]         m_data;
    logic               m_valid;
    logic               m_ready = 1'b0;
    logic               m_last;
    logic               busy;

    logic [OS*8-1:0] lay_out;
    logic            lay_valid;
    logic            spur = 1'b0;

    int errors = 0;
    int checks = 0;
    int x_m[IS];
    int w_m[OS*IS];
    int b_m[OS];
    bit loaded_m = 1'b0;

    fc_stream_driver #(.INPUT_SIZE(IS), .OUTPUT_SIZE(OS)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_params(s_params),
        .fc_in_vec(fc_in_vec), .fc_weights(fc_weights), .fc_bias(fc_bias), .fc_en(fc_en),
        .fc_out_vec(fc_out_vec), .fc_valid(fc_valid),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .busy(busy)
    );

    function automatic logic [7:0] sat8(input int v);
        return (v > 127) ? 8'h7f : (v < -128) ? 8'h80 : 8'(v);
    endfunction

    function automatic int rnd8();
        logic [7:0] r;
        r = 8'($urandom);
        return int'($signed(r));
    endfunction

    // Stand-in for fully_connected_int8: one-cycle latency from en to valid.
    always @(posedge clk) begin
        if (rst) begin
            lay_valid <= 1'b0;
            lay_out   <= '0;
        end else begin
            lay_valid <= fc_en;
            if (fc_en) begin
                for (int o = 0; o < OS; o++) begin
                    int acc;
                    acc = $signed(fc_bias[o*8 +: 8]);
                    for (int i = 0; i < IS; i++)
                        acc += $signed(fc_weights[(o*IS+i)*8 +: 8]) * $signed(fc_in_vec[i*8 +: 8]);
                    lay_out[o*8 +: 8] <= sat8(acc);
                end
            end
        end
    end

    // Spurious valids with junk data probe that fc_valid is ignored while loading.
    assign fc_valid   = lay_valid | spur;
    assign fc_out_vec = lay_valid ? lay_out : {OS{8'hA5}};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic p, input bit gap);
        int n;
        if (gap) begin
            s_valid = 1'b0;
            spur = 1'($urandom_range(0, 1));
            tick();
        end
        s_data = d;
        s_params = p;
        s_valid = 1'b1;
        spur = ($urandom_range(0, 3) == 0);
        n = 0;
        while (!s_ready && n < 50) begin
            tick();
            n++;
        end
        if (!s_ready) chk("s_ready_timeout", 64'(s_ready), 64'd1);
        tick();
        s_valid = 1'b0;
        spur = 1'b0;
    endtask

    task automatic check_buses();
        logic [IS*8-1:0]    px;
        logic [OS*IS*8-1:0] pw;
        logic [OS*8-1:0]    pb;
        for (int i = 0; i < IS; i++) px[i*8 +: 8] = 8'(x_m[i]);
        for (int k = 0; k < OS*IS; k++) pw[k*8 +: 8] = 8'(w_m[k]);
        for (int o = 0; o < OS; o++) pb[o*8 +: 8] = 8'(b_m[o]);
        chk("fc_in_vec", 64'(fc_in_vec), 64'(px));
        chk("fc_weights", 64'(fc_weights), 64'(pw));
        chk("fc_bias", 64'(fc_bias), 64'(pb));
    endtask

    // gapmode: 0 none, 1 every other cycle, 2 random; stallmode: 0 random, 1 five-cycle stall mid-send
    task automatic run_frame(input int x[IS], input bit p, input int w[OS*IS], input int b[OS],
                             input int gapmode, input int stallmode, input bit abort_send);
        bit flag;
        int total;
        int v;
        logic [7:0] exp;
        flag = p || !loaded_m;
        total = IS + (flag ? OS*IS + OS : 0);
        for (int k = 0; k < total; k++) begin
            v = (k < IS) ? x[k] : (k < IS + OS*IS) ? w[k-IS] : b[k-IS-OS*IS];
            push(8'(v), (k == 0) ? p : 1'($urandom_range(0, 1)),
                 gapmode == 1 || (gapmode == 2 && $urandom_range(0, 2) == 0));
            if (k < total - 1) begin
                chk("early_fc_en", 64'(fc_en), 64'd0);
                chk("busy_load", 64'(busy), 64'd1);
            end
        end
        x_m = x;
        if (flag) begin
            w_m = w;
            b_m = b;
            loaded_m = 1'b1;
        end
        chk("fc_en_t1", 64'(fc_en), 64'd1);
        chk("s_ready_fire", 64'(s_ready), 64'd0);
        check_buses();
        tick();
        chk("fc_en_t2", 64'(fc_en), 64'd0);
        chk("m_valid_t2", 64'(m_valid), 64'd0);
        check_buses();
        tick();
        chk("m_valid_t3", 64'(m_valid), 64'd1);
        if (abort_send) begin
            rst = 1'b1;
            #1;
            chk("m_valid_rst", 64'(m_valid), 64'd0);
            tick();
            chk("fc_bias_rst", 64'(fc_bias), 64'd0);
            rst = 1'b0;
            loaded_m = 1'b0;
            #1;
            chk("s_ready_after_rst", 64'(s_ready), 64'd1);
            return;
        end
        for (int e = 0; e < OS; e++) begin
            int acc;
            int stall;
            acc = b_m[e];
            for (int i = 0; i < IS; i++) acc += w_m[e*IS+i] * x_m[i];
            exp = sat8(acc);
            stall = (stallmode == 1) ? ((e == OS/2) ? 5 : 0) : $urandom_range(0, 2);
            m_ready = 1'b0;
            repeat (stall) begin
                tick();
                chk("hold_valid", 64'(m_valid), 64'd1);
                chk("hold_data", 64'(m_data), 64'(exp));
                chk("hold_last", 64'(m_last), 64'(e == OS-1));
                chk("s_ready_send", 64'(s_ready), 64'd0);
            end
            chk("m_valid", 64'(m_valid), 64'd1);
            chk("m_data", 64'(m_data), 64'(exp));
            chk("m_last", 64'(m_last), 64'(e == OS-1));
            chk("s_ready_send", 64'(s_ready), 64'd0);
            m_ready = 1'b1;
            tick();
            m_ready = 1'b0;
        end
        chk("s_ready_next", 64'(s_ready), 64'd1);
        chk("m_valid_done", 64'(m_valid), 64'd0);
        chk("busy_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rx[IS];
        int rw[OS*IS];
        int rbv[OS];
        rst = 1'b1;
        repeat (3) begin
            tick();
            chk("rst_s_ready", 64'(s_ready), 64'd0);
        end
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_fc_en", 64'(fc_en), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_buses", 64'(fc_in_vec | fc_weights | fc_bias), 64'd0);
        rst = 1'b0;
        #1;
        chk("s_ready_first", 64'(s_ready), 64'd1);
        chk("busy_first", 64'(busy), 64'd0);

        run_frame('{1, 2, 3, 4}, 1'b1, '{1, 1, 1, 1, -1, 0, 0, 0}, '{5, -3}, 0, 0, 1'b0);
        run_frame('{10, 10, 10, 10}, 1'b0, '{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0}, 0, 0, 1'b0);
        for (int i = 0; i < IS; i++) rx[i] = rnd8();
        run_frame(rx, 1'b0, rw, rbv, 1, 1, 1'b0);

        // reset in the middle of the weight load
        for (int i = 0; i < IS; i++) push(8'(i + 7), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) push(8'(i + 1), 1'b0, 1'b0);
        chk("busy_mid_w", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        chk("fc_weights_rst", 64'(fc_weights), 64'd0);
        chk("fc_in_vec_rst", 64'(fc_in_vec), 64'd0);
        chk("busy_rst", 64'(busy), 64'd0);
        rst = 1'b0;
        loaded_m = 1'b0;
        #1;
        chk("s_ready_rel", 64'(s_ready), 64'd1);
        for (int i = 0; i < IS; i++) rx[i] = rnd8();
        for (int k = 0; k < OS*IS; k++) rw[k] = rnd8();
        for (int o = 0; o < OS; o++) rbv[o] = rnd8();
        run_frame(rx, 1'b0, rw, rbv, 2, 0, 1'b0);

        for (int f = 0; f < 10; f++) begin
            for (int i = 0; i < IS; i++) rx[i] = rnd8();
            for (int k = 0; k < OS*IS; k++) rw[k] = rnd8();
            for (int o = 0; o < OS; o++) rbv[o] = rnd8();
            run_frame(rx, 1'($urandom_range(0, 1)), rw, rbv, $urandom_range(0, 2),
                      $urandom_range(0, 1), f == 4);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fc_stream_driver.md
# fc_stream_driver

Front-end/back-end adapter for `fully_connected_int8`. Accepts one inference frame as a byte stream (activations, then optionally weights and biases) and packs it into the layer's flattened `in_vec`/`weights`/`bias` buses. It then pulses the layer enable, captures the saturated INT8 result on the layer's `valid`, and streams the OUTPUT_SIZE result bytes out over a valid/ready interface. It sits between the DMA/testbench byte streams and the parallel FC layer.

## Interface
- INPUT_SIZE, 128, activations per frame; must match the attached layer.
- OUTPUT_SIZE, 10, output neurons; must match the attached layer.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_data  in  8  inbound byte: activation, weight or bias, two's complement.
- s_valid  in  1  inbound byte valid.
- s_ready  out  1  inbound byte ready; transfer when s_valid && s_ready.
- s_params  in  1  sampled only with byte 0 of a frame; 1 = frame carries weights+biases.
- fc_in_vec  out  INPUT_SIZE*8  to layer `in_vec`; byte k at [k*8+:8].
- fc_weights  out  OUTPUT_SIZE*INPUT_SIZE*8  to layer `weights`; byte k = o*INPUT_SIZE+i at [k*8+:8].
- fc_bias  out  OUTPUT_SIZE*8  to layer `bias`; byte o at [o*8+:8].
- fc_en  out  1  one-cycle compute strobe to layer `en`.
- fc_out_vec  in  OUTPUT_SIZE*8  from layer `out_vec`.
- fc_valid  in  1  from layer `valid`.
- m_data  out  8  result byte, element 0 first.
- m_valid  out  1  result byte valid.
- m_ready  in  1  result byte ready.
- m_last  out  1  high with the byte for element OUTPUT_SIZE-1.
- busy  out  1  frame in progress: loading past byte 0, FIRE, WAIT or SEND.

## Operation
- States: LOAD_IN, LOAD_W, LOAD_B, FIRE, WAIT, SEND. Reset state is LOAD_IN.
- Byte counter: width clog2(OUTPUT_SIZE*INPUT_SIZE) (minimum 1); it resets to 0 on every state entry.
- s_ready=1 only in LOAD_IN, LOAD_W and LOAD_B. Each accepted byte is written to the addressed slot and increments the counter. Cycles without s_valid do not advance the counter.
- LOAD_IN byte 0 latches the params flag: flag = s_params | !weights_loaded. So a frame after reset with no weights stored always loads parameters.
- LOAD_IN: after INPUT_SIZE bytes, go to LOAD_W if the flag is set, else go to FIRE.
- LOAD_W: after OUTPUT_SIZE*INPUT_SIZE bytes, go to LOAD_B.
- LOAD_B: after OUTPUT_SIZE bytes, set weights_loaded and go to FIRE.
- FIRE: fc_en=1 for exactly this one cycle, decoded from the registered state. Next state is WAIT.
- WAIT: when fc_valid=1, capture fc_out_vec into the result register and go to SEND. With no fc_valid, stay in WAIT indefinitely; there is no timeout.
- SEND: m_valid=1, m_data = result[idx*8+:8], m_last = (idx==OUTPUT_SIZE-1). On each handshake, idx++. After the last handshake, go to LOAD_IN.
- Stored weights and biases persist across frames until a params frame overwrites them, or until reset.
- fc_* buses change only on accepted load bytes. They are stable throughout FIRE and WAIT.
- fc_valid outside WAIT is ignored. The driver performs no arithmetic; result bytes pass through bit-exact.

## Timing
- Reset values: s_ready 0 while rst=1; all other outputs 0. fc_* buses 0, weights_loaded 0, counters 0.
- First cycle after rst deasserts: s_ready=1.
- Last load byte accepted in cycle t: fc_en high in t+1, layer valid in t+2, capture at the end of t+2, m_valid high from t+3.
- m_data and m_last are held stable while m_valid && !m_ready.
- The last result handshake in cycle u gives s_ready=1 in u+1. Load and send never overlap.
- rst mid-frame (any state): return to LOAD_IN next cycle. The partial frame is discarded, weights_loaded and all buses are cleared, and m_valid drops immediately.

## Test plan
Use INPUT_SIZE=4, OUTPUT_SIZE=2, with a real `fully_connected_int8` attached.
- Reset check: hold rst for 3 cycles, then release -> all outputs 0 during reset; s_ready=1 first cycle after; busy=0.
- Full frame, s_params=1: in=[1,2,3,4], W=[1,1,1,1, -1,0,0,0], bias=[5,-3] -> fc_en high exactly 1 cycle; m_valid 3 cycles after the last byte; m_data 0x0F then 0xFC; m_last on the second byte only.
- Activations-only frame, s_params=0, in=[10,10,10,10] -> s_ready drops after 4 bytes; outputs 0x2D then 0xF3 (stored weights reused).
- s_params=0 as the first frame after reset -> treated as a params frame: consumes 4+8+2=14 bytes before fc_en.
- Backpressure and gaps: s_valid toggled every other cycle, m_ready low 5 cycles mid-SEND -> counter advances only on handshakes; m_data and m_last held; s_ready=0 throughout SEND; correct byte sequence.
- Assert rst in LOAD_W after 3 weight bytes -> state LOAD_IN and fc_weights=0 next cycle. A following s_params=0 frame is forced to load parameters.
